// File: rtl/matmul_apb_master_if.sv
// Bundles the command, response, APB and busy signals of the matmul APB master.
// Signal suffixes are from the master's point of view.
interface matmul_apb_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Command channel
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic                cmd_write_i;
  logic [ADDR_W-1:0]   cmd_addr_i;
  logic [DATA_W-1:0]   cmd_wdata_i;
  logic [DATA_W/8-1:0] cmd_strb_i;

  // Response channel
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [DATA_W-1:0]   rsp_rdata_o;
  logic                rsp_err_o;
  logic                rsp_timeout_o;

  // APB bus towards the matmul slave
  logic                psel_o;
  logic                penable_o;
  logic                pwrite_o;
  logic [ADDR_W-1:0]   paddr_o;
  logic [DATA_W-1:0]   pwdata_o;
  logic [DATA_W/8-1:0] pstrb_o;
  logic                pready_i;
  logic                pslverr_i;
  logic [DATA_W-1:0]   prdata_i;

  // Matmul status
  logic                busy_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    input  pready_i, pslverr_i, prdata_i,
    input  busy_i
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
    output pready_i, pslverr_i, prdata_i,
    output busy_i
  );
endinterface

// File: rtl/matmul_apb_master.sv
// APB master for the matmul accelerator: turns one command at a time into an
// APB SETUP/ACCESS transfer, with a bounded wait for PREADY and a held response.
module matmul_apb_master #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int HOLD_WR_ON_BUSY = 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  matmul_apb_master_if.master  bus
);

  localparam int          STRB_W    = DATA_W / 8;
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q;
  logic [7:0]          wait_q;
  logic [7:0]          wait_d;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                psel_q;
  logic                penable_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic                rsp_timeout_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                hold_wr;
  logic                cmd_ready;

  // Accept gating and the next wait-counter value; reads are never held by busy.
  always_comb begin
    hold_wr   = (HOLD_WR_ON_BUSY != 0) && bus.cmd_write_i && bus.busy_i;
    cmd_ready = rst_ni && (state_q == IDLE) && !hold_wr;
    wait_d    = wait_q + 8'd1;
  end

  // Transfer FSM with registered APB controls, captured command and response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid_i && cmd_ready) begin
            write_q <= bus.cmd_write_i;
            addr_q  <= bus.cmd_addr_i;
            wdata_q <= bus.cmd_wdata_i;
            strb_q  <= bus.cmd_write_i ? bus.cmd_strb_i : '0;
            psel_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_q    <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready_i) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= bus.pslverr_i;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= write_q ? '0 : bus.prdata_i;
            state_q       <= RESP;
          end else if (wait_q == WAIT_LAST) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            state_q       <= RESP;
          end else begin
            wait_q <= wait_d;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o   = cmd_ready;
  assign bus.psel_o        = psel_q;
  assign bus.penable_o     = penable_q;
  assign bus.pwrite_o      = write_q;
  assign bus.paddr_o       = addr_q;
  assign bus.pwdata_o      = wdata_q;
  assign bus.pstrb_o       = strb_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Self-checking bench for matmul_apb_master: directed scenarios plus random
// transfers, compared against an arithmetic transfer-outcome model.
module tb_matmul_apb_master;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  matmul_apb_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  matmul_apb_master #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT),
    .HOLD_WR_ON_BUSY(1)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All reset-cleared outputs must read zero.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_psel"},    64'(bus.psel_o), 64'd0);
    checkOutput({tag, "_penable"}, 64'(bus.penable_o), 64'd0);
    checkOutput({tag, "_pwrite"},  64'(bus.pwrite_o), 64'd0);
    checkOutput({tag, "_paddr"},   64'(bus.paddr_o), 64'd0);
    checkOutput({tag, "_pwdata"},  64'(bus.pwdata_o), 64'd0);
    checkOutput({tag, "_pstrb"},   64'(bus.pstrb_o), 64'd0);
    checkOutput({tag, "_rvalid"},  64'(bus.rsp_valid_o), 64'd0);
    checkOutput({tag, "_rerr"},    64'(bus.rsp_err_o), 64'd0);
    checkOutput({tag, "_rto"},     64'(bus.rsp_timeout_o), 64'd0);
    checkOutput({tag, "_rdata"},   64'(bus.rsp_rdata_o), 64'd0);
    checkOutput({tag, "_cready"},  64'(bus.cmd_ready_o), 64'd0);
  endtask

  // Runs one complete transfer. The slave raises pready after nWait wait
  // states (never, if nWait >= TIMEOUT). Expected outcome comes from the model.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int nWait, input logic slverr,
                               input logic [31:0] rdata, input logic busyAtAccept, input int holdCycles);
    logic        timedOut;
    int          accessCycles;
    logic        expErr;
    logic        expTo;
    logic [31:0] expRdata;
    logic [3:0]  expStrb;
    int          expLat;
    int          lat;
    int          seen;
    logic        gotRsp;
    logic [31:0] heldRdata;
    timedOut     = (nWait >= TIMEOUT);
    accessCycles = timedOut ? TIMEOUT : nWait + 1;
    expErr       = timedOut ? 1'b1 : slverr;
    expTo        = timedOut;
    expRdata     = (timedOut || wr) ? 32'd0 : rdata;
    expStrb      = wr ? strb : 4'd0;
    expLat       = accessCycles + 2;

    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = wr;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = wdata;
    bus.cmd_strb_i  = strb;
    bus.busy_i      = busyAtAccept;
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0;
    #1;
    checkOutput("accept_ready", 64'(bus.cmd_ready_o), 64'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = ~wr;
    bus.cmd_addr_i  = $urandom;
    bus.cmd_wdata_i = $urandom;
    bus.cmd_strb_i  = 4'($urandom);
    bus.busy_i      = 1'($urandom);
    checkOutput("setup_psel",    64'(bus.psel_o), 64'd1);
    checkOutput("setup_penable", 64'(bus.penable_o), 64'd0);
    checkOutput("setup_pwrite",  64'(bus.pwrite_o), 64'(wr));
    checkOutput("setup_paddr",   64'(bus.paddr_o), 64'(addr));
    checkOutput("setup_pwdata",  64'(bus.pwdata_o), 64'(wdata));
    checkOutput("setup_pstrb",   64'(bus.pstrb_o), 64'(expStrb));
    checkOutput("setup_cready",  64'(bus.cmd_ready_o), 64'd0);

    seen   = 0;
    gotRsp = 1'b0;
    for (int c = 0; c < TIMEOUT + 4; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.rsp_valid_o === 1'b1) begin
        gotRsp = 1'b1;
        break;
      end
      seen++;
      checkOutput("access_psel",    64'(bus.psel_o), 64'd1);
      checkOutput("access_penable", 64'(bus.penable_o), 64'd1);
      checkOutput("access_paddr",   64'(bus.paddr_o), 64'(addr));
      checkOutput("access_pwdata",  64'(bus.pwdata_o), 64'(wdata));
      checkOutput("access_pstrb",   64'(bus.pstrb_o), 64'(expStrb));
      checkOutput("access_pwrite",  64'(bus.pwrite_o), 64'(wr));
      bus.pready_i  = (!timedOut && (seen - 1 == nWait));
      bus.pslverr_i = bus.pready_i ? slverr : 1'($urandom);
      bus.prdata_i  = bus.pready_i ? rdata : $urandom;
      bus.busy_i    = 1'($urandom);
    end
    bus.pready_i = 1'b0;
    checkOutput("rsp_seen",      64'(gotRsp), 64'd1);
    checkOutput("access_cycles", 64'(seen), 64'(accessCycles));
    checkOutput("latency",       64'(lat), 64'(expLat));
    checkOutput("rsp_psel",      64'(bus.psel_o), 64'd0);
    checkOutput("rsp_penable",   64'(bus.penable_o), 64'd0);
    checkOutput("rsp_err",       64'(bus.rsp_err_o), 64'(expErr));
    checkOutput("rsp_timeout",   64'(bus.rsp_timeout_o), 64'(expTo));
    checkOutput("rsp_rdata",     64'(bus.rsp_rdata_o), 64'(expRdata));

    heldRdata = expRdata;
    for (int h = 0; h < holdCycles; h++) begin
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = 1'b0;
      bus.busy_i      = 1'b0;
      bus.prdata_i    = $urandom;
      bus.pslverr_i   = 1'($urandom);
      #1;
      checkOutput("hold_cready", 64'(bus.cmd_ready_o), 64'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_valid", 64'(bus.rsp_valid_o), 64'd1);
      checkOutput("hold_rdata", 64'(bus.rsp_rdata_o), 64'(heldRdata));
      checkOutput("hold_err",   64'(bus.rsp_err_o), 64'(expErr));
      checkOutput("hold_to",    64'(bus.rsp_timeout_o), 64'(expTo));
      checkOutput("hold_psel",  64'(bus.psel_o), 64'd0);
    end
    bus.rsp_ready_i = 1'b1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b0;
    bus.busy_i      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.cmd_valid_i = 1'b0;
    checkOutput("consume_valid",  64'(bus.rsp_valid_o), 64'd0);
    checkOutput("consume_noacc",  64'(bus.psel_o), 64'd0);
    checkOutput("consume_cready", 64'(bus.cmd_ready_o), 64'd1);
  endtask

  initial begin
    compared        = 0;
    mismatched      = 0;
    rst_n           = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    bus.cmd_strb_i  = '0;
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0;
    bus.pslverr_i   = 1'b0;
    bus.prdata_i    = '0;
    bus.busy_i      = 1'b0;

    // Reset state before any clock edge
    #3;
    checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_cready", 64'(bus.cmd_ready_o), 64'd1);

    $display("[TB] directed: single-cycle write");
    applyStimulus(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'hAAAA_5555, 1'b0, 0);

    $display("[TB] directed: read with three wait states");
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 1'b0, 0);

    $display("[TB] directed: write with slave error");
    applyStimulus(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 32'h0, 1'b0, 0);

    $display("[TB] directed: timeout");
    applyStimulus(1'b0, 32'h0000_0030, 32'h0, 4'h0, TIMEOUT, 1'b0, 32'hFFFF_FFFF, 1'b0, 0);

    $display("[TB] directed: write held by busy");
    @(negedge clk);
    bus.busy_i      = 1'b1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b1;
    bus.cmd_addr_i  = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("busy_hold_cready", 64'(bus.cmd_ready_o), 64'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("busy_hold_psel", 64'(bus.psel_o), 64'd0);
    end
    applyStimulus(1'b1, 32'h0000_0040, 32'hCAFE_0001, 4'h5, 2, 1'b0, 32'h0, 1'b0, 0);

    $display("[TB] directed: read accepted while busy");
    applyStimulus(1'b0, 32'h0000_0044, 32'h0, 4'hF, 0, 1'b0, 32'h8765_4321, 1'b1, 0);

    $display("[TB] directed: response held five cycles");
    applyStimulus(1'b0, 32'h0000_0048, 32'h0, 4'hF, 1, 1'b0, 32'h5A5A_A5A5, 1'b0, 5);

    $display("[TB] directed: reset during ACCESS");
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = 1'b1;
    bus.cmd_addr_i  = 32'h0000_0050;
    bus.cmd_wdata_i = 32'h1111_2222;
    bus.cmd_strb_i  = 4'hF;
    bus.busy_i      = 1'b0;
    bus.pready_i    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("pre_rst_penable", 64'(bus.penable_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.pready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("after_rst_rvalid", 64'(bus.rsp_valid_o), 64'd0);
      checkOutput("after_rst_psel",   64'(bus.psel_o), 64'd0);
      checkOutput("after_rst_cready", 64'(bus.cmd_ready_o), 64'd1);
    end
    bus.pready_i = 1'b0;

    $display("[TB] random transfers");
    for (int t = 0; t < 24; t++) begin
      logic        rw;
      int          nw;
      rw = 1'($urandom);
      nw = ($urandom_range(0, 7) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, 5));
      applyStimulus(rw, $urandom, $urandom, 4'($urandom), nw, 1'($urandom), $urandom,
                    rw ? 1'b0 : 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matmul_apb_master.md
MATMUL_APB_MASTER -- requirements
Module: matmul_apb_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, APB data width; strobe width is DATA_W/8.
- ADDR_W, 32, APB address width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; legal range 1..255.
- HOLD_WR_ON_BUSY, 1, when 1, write commands are not accepted while busy_i=1.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock; all state changes on the rising edge.
- rst_ni, in, 1, asynchronous active-low reset.
- cmd_valid_i, in, 1, command request.
- cmd_ready_o, out, 1, command accepted when high together with cmd_valid_i.
- cmd_write_i, in, 1, 1 for write, 0 for read.
- cmd_addr_i, in, ADDR_W, target address.
- cmd_wdata_i, in, DATA_W, write data.
- cmd_strb_i, in, DATA_W/8, byte strobes.
- rsp_valid_o, out, 1, response available.
- rsp_ready_i, in, 1, response consumed.
- rsp_rdata_o, out, DATA_W, read data.
- rsp_err_o, out, 1, slave error or timeout.
- rsp_timeout_o, out, 1, transfer aborted by timeout.
- psel_o, penable_o, pwrite_o, out, 1 each, APB control to the matmul slave.
- paddr_o, out, ADDR_W, APB address.
- pwdata_o, out, DATA_W, APB write data.
- pstrb_o, out, DATA_W/8, APB write strobes.
- pready_i, pslverr_i, in, 1 each, APB slave responses.
- prdata_i, in, DATA_W, APB read data.
- busy_i, in, 1, matmul busy indication.

REQ-003 There SHALL be one clock, clk_i; reset rst_ni SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have four states: IDLE, SETUP, ACCESS, RESP. At most one transfer SHALL be outstanding.
REQ-005 cmd_ready_o SHALL be 1 only in IDLE, and only when not (HOLD_WR_ON_BUSY=1 and cmd_write_i=1 and busy_i=1). Reads SHALL never be held by busy_i.
REQ-006 When cmd_valid_i and cmd_ready_o are both 1 at an edge, the block SHALL register write, addr, wdata and strb, and enter SETUP.
REQ-007 In SETUP, psel_o SHALL be 1 and penable_o 0. On the next edge the FSM SHALL enter ACCESS unconditionally.
REQ-008 In ACCESS, psel_o and penable_o SHALL both be 1.
REQ-009 paddr_o, pwrite_o, pwdata_o and pstrb_o SHALL hold the registered values, stable from SETUP through the final ACCESS cycle.
REQ-010 pstrb_o SHALL be all-zero for reads.
REQ-011 In ACCESS, a wait counter SHALL clear on ACCESS entry and increment on each ACCESS cycle with pready_i=0.
REQ-012 If pready_i=1 in ACCESS, the FSM SHALL enter RESP with these captured values:
- rsp_err_o = pslverr_i;
- rsp_timeout_o = 0;
- rsp_rdata_o = prdata_i for reads, 0 for writes.
REQ-013 If pready_i=0 and the wait counter equals TIMEOUT_CYCLES-1, the FSM SHALL enter RESP with rsp_err_o=1, rsp_timeout_o=1 and rsp_rdata_o=0. psel_o and penable_o SHALL drop to 0 at that edge.
REQ-014 Outside SETUP and ACCESS, psel_o and penable_o SHALL be 0.
REQ-015 In RESP, rsp_valid_o SHALL be 1 and the response fields SHALL be held stable. On an edge with rsp_ready_i=1, the FSM SHALL return to IDLE.
REQ-016 Minimum command-accept to rsp_valid_o latency SHALL be 3 cycles: accept edge, SETUP, ACCESS with pready_i=1. Each wait state SHALL add 1 cycle.
REQ-017 A new command SHALL NOT be accepted in the cycle rsp_valid_o is consumed; the earliest new accept is the following cycle in IDLE.
REQ-018 busy_i changes SHALL NOT affect a transfer already past IDLE.
REQ-019 pslverr_i and prdata_i SHALL be ignored unless psel_o=1, penable_o=1 and pready_i=1.

Reset
REQ-020 While rst_ni=0, the following SHALL be 0 immediately, independent of clk_i:
- psel_o, penable_o, pwrite_o;
- rsp_valid_o, rsp_err_o, rsp_timeout_o;
- cmd_ready_o;
- paddr_o, pwdata_o, pstrb_o, rsp_rdata_o;
- the wait counter.
The FSM SHALL be in IDLE.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer with no response generated. After rst_ni rises, cmd_ready_o SHALL follow REQ-005 from the first edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write addr 0x0000_0004, data 0xDEAD_BEEF, strb 0xF, pready_i=1 in first ACCESS -> APB SETUP then one ACCESS cycle with matching paddr/pwdata/pstrb; rsp_valid_o 3 cycles after accept; rsp_err_o=0, rsp_rdata_o=0.
- Read addr 0x10, pready_i low for 3 ACCESS cycles then high with prdata_i=0x1234_5678 -> 4 ACCESS cycles; rsp_rdata_o=0x1234_5678; latency 6.
- Write with pslverr_i=1 at pready_i -> rsp_err_o=1, rsp_timeout_o=0.
- pready_i held 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then rsp_err_o=1, rsp_timeout_o=1, psel_o=0.
- busy_i=1 with pending write -> cmd_ready_o=0 until busy_i falls; a read with busy_i=1 is accepted immediately.
- rsp_ready_i=0 for 5 cycles in RESP -> response held stable, no new accept. Reset pulsed during ACCESS -> psel_o/penable_o drop asynchronously and no rsp_valid_o.
